// File: rtl/demux2_resp_router_if.sv
// Bundle of request, response and routed-output signals for demux2_resp_router.
// The router is the slave; whatever issues requests and watches the outputs is the master.
interface demux2_resp_router_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  logic                         req_valid;
  logic                         req_sel;
  logic                         req_ready;
  logic                         rsp_valid;
  logic [WIDTH-1:0]             rsp_data;
  logic [WIDTH-1:0]             y0;
  logic                         y0_valid;
  logic [WIDTH-1:0]             y1;
  logic                         y1_valid;
  logic [$clog2(DEPTH+1)-1:0]   pending;
  logic                         err;

  modport master (
    output req_valid, req_sel, rsp_valid, rsp_data,
    input  req_ready, y0, y0_valid, y1, y1_valid, pending, err
  );

  modport slave (
    input  req_valid, req_sel, rsp_valid, rsp_data,
    output req_ready, y0, y0_valid, y1, y1_valid, pending, err
  );
endinterface

// File: rtl/demux2_resp_router.sv
// Return-path router: remembers which requester issued each read, in order, and steers
// each returning word to the registered y0 (data access) or y1 (instruction) output.
module demux2_resp_router #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  demux2_resp_router_if.slave  bus
);
  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] tag_q,     tag_d;
  logic [PtrW-1:0]  wrPtr_q,   wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q,   rdPtr_d;
  logic [CntW-1:0]  count_q,   count_d;
  logic [WIDTH-1:0] y0_q,      y0_d;
  logic [WIDTH-1:0] y1_q,      y1_d;
  logic             y0Valid_q, y0Valid_d;
  logic             y1Valid_q, y1Valid_d;
  logic             err_q,     err_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic headTag;

  // Full/empty use only the registered count, so a same-cycle pop never frees a slot
  // for a push and a same-cycle push never feeds a response (that response is an orphan).
  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    push      = bus.req_valid && !full;
    pop       = bus.rsp_valid && !empty;
    headTag   = tag_q[rdPtr_q];

    tag_d     = tag_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    y0Valid_d = 1'b0;
    y1Valid_d = 1'b0;
    err_d     = err_q;

    if (push) begin
      tag_d[wrPtr_q] = bus.req_sel;
      wrPtr_d        = wrPtr_q + PtrW'(1);
    end

    if (pop) begin
      rdPtr_d = rdPtr_q + PtrW'(1);
      if (headTag) begin
        y1_d      = bus.rsp_data;
        y1Valid_d = 1'b1;
      end else begin
        y0_d      = bus.rsp_data;
        y0Valid_d = 1'b1;
      end
    end else if (bus.rsp_valid) begin
      err_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q     <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      y0Valid_q <= 1'b0;
      y1Valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      y0Valid_q <= y0Valid_d;
      y1Valid_q <= y1Valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = !full;
  assign bus.y0        = y0_q;
  assign bus.y1        = y1_q;
  assign bus.y0_valid  = y0Valid_q;
  assign bus.y1_valid  = y1Valid_q;
  assign bus.pending   = count_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_demux2_resp_router.sv
// Self-checking bench for demux2_resp_router: directed table, random traffic against a
// queue-based reference model, and an asynchronous reset in the middle of traffic.
module tb_demux2_resp_router;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  demux2_resp_router_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux2_resp_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rv;
    logic        rs;
    logic        pv;
    logic [31:0] pd;
    logic [31:0] y0;
    logic [31:0] y1;
    logic        v0;
    logic        v1;
    int          pend;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  // Reference model: the outstanding requesters are just a queue of tags.
  bit          mq[$];
  logic [31:0] mY0;
  logic [31:0] mY1;
  logic        mV0;
  logic        mV1;
  logic        mErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(logic rv, logic rs, logic pv, logic [31:0] pd,
                                 logic [31:0] y0, logic [31:0] y1, logic v0, logic v1,
                                 int pend, logic rdy, logic err);
    vec_t v;
    v.rv = rv; v.rs = rs; v.pv = pv; v.pd = pd;
    v.y0 = y0; v.y1 = y1; v.v0 = v0; v.v1 = v1;
    v.pend = pend; v.rdy = rdy; v.err = err;
    return v;
  endfunction

  task automatic modelReset();
    mq.delete();
    mY0  = '0;
    mY1  = '0;
    mV0  = 1'b0;
    mV1  = 1'b0;
    mErr = 1'b0;
  endtask

  task automatic modelEdge(input logic rv, input logic rs, input logic pv, input logic [31:0] pd);
    bit pushOk;
    bit tag;
    pushOk = rv && (mq.size() < DEPTH);
    mV0 = 1'b0;
    mV1 = 1'b0;
    if (pv) begin
      if (mq.size() != 0) begin
        tag = mq.pop_front();
        if (tag) begin mY1 = pd; mV1 = 1'b1; end
        else     begin mY0 = pd; mV0 = 1'b1; end
      end else begin
        mErr = 1'b1;
      end
    end
    if (pushOk) mq.push_back(rs);
  endtask

  task automatic driveInputs(input logic rv, input logic rs, input logic pv, input logic [31:0] pd);
    bus.req_valid = rv;
    bus.req_sel   = rs;
    bus.rsp_valid = pv;
    bus.rsp_data  = pd;
  endtask

  task automatic applyStimulus(input logic rv, input logic rs, input logic pv, input logic [31:0] pd);
    driveInputs(rv, rs, pv, pd);
    @(posedge clk);
    modelEdge(rv, rs, pv, pd);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".y0"},       bus.y0, mY0);
    check({tag, ".y1"},       bus.y1, mY1);
    check({tag, ".y0_valid"}, 32'(bus.y0_valid), 32'(mV0));
    check({tag, ".y1_valid"}, 32'(bus.y1_valid), 32'(mV1));
    check({tag, ".pending"},  32'(bus.pending), 32'(mq.size()));
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(mq.size() < DEPTH));
    check({tag, ".err"},      32'(bus.err), 32'(mErr));
  endtask

  task automatic resetSequence();
    reset = 1'b1;
    driveInputs(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic        sel;
    logic        rv;
    logic        pv;
    logic [31:0] pd;

    vecs[0]  = mkVec(1, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 0);
    vecs[1]  = mkVec(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 0);
    vecs[2]  = mkVec(0, 0, 1, 32'h00500093, 32'h0,        32'h00500093, 0, 1, 0, 1, 0);
    vecs[3]  = mkVec(0, 0, 0, 32'h0,        32'h0,        32'h00500093, 0, 0, 0, 1, 0);
    vecs[4]  = mkVec(1, 0, 0, 32'h0,        32'h0,        32'h00500093, 0, 0, 1, 1, 0);
    vecs[5]  = mkVec(1, 1, 0, 32'h0,        32'h0,        32'h00500093, 0, 0, 2, 0, 0);
    vecs[6]  = mkVec(1, 0, 0, 32'h0,        32'h0,        32'h00500093, 0, 0, 2, 0, 0);
    vecs[7]  = mkVec(0, 0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00500093, 1, 0, 1, 1, 0);
    vecs[8]  = mkVec(0, 0, 1, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 0, 1, 0, 1, 0);
    vecs[9]  = mkVec(1, 1, 0, 32'h0,        32'hA5A5A5A5, 32'h12345678, 0, 0, 1, 1, 0);
    vecs[10] = mkVec(1, 0, 0, 32'h0,        32'hA5A5A5A5, 32'h12345678, 0, 0, 2, 0, 0);
    vecs[11] = mkVec(1, 1, 1, 32'h11111111, 32'hA5A5A5A5, 32'h11111111, 0, 1, 1, 1, 0);
    vecs[12] = mkVec(1, 1, 1, 32'h22222222, 32'h22222222, 32'h11111111, 1, 0, 1, 1, 0);
    vecs[13] = mkVec(0, 0, 1, 32'h33333333, 32'h22222222, 32'h33333333, 0, 1, 0, 1, 0);
    vecs[14] = mkVec(0, 0, 1, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0, 0, 0, 1, 1);
    vecs[15] = mkVec(1, 0, 1, 32'hCAFEF00D, 32'h22222222, 32'h33333333, 0, 0, 1, 1, 1);
    vecs[16] = mkVec(0, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 32'h33333333, 1, 0, 0, 1, 1);

    resetSequence();
    checkOutput("reset");

    // Directed table: in-order routing, full stall, push+pop, orphan and same-cycle push.
    for (int i = 0; i < 17; i++) begin
      driveInputs(vecs[i].rv, vecs[i].rs, vecs[i].pv, vecs[i].pd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.y0", i),        bus.y0, vecs[i].y0);
      check($sformatf("vec%0d.y1", i),        bus.y1, vecs[i].y1);
      check($sformatf("vec%0d.y0_valid", i),  32'(bus.y0_valid), 32'(vecs[i].v0));
      check($sformatf("vec%0d.y1_valid", i),  32'(bus.y1_valid), 32'(vecs[i].v1));
      check($sformatf("vec%0d.pending", i),   32'(bus.pending), 32'(vecs[i].pend));
      check($sformatf("vec%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d.err", i),       32'(bus.err), 32'(vecs[i].err));
    end

    // Random well-formed traffic: alternating requesters, random response latency, no orphans.
    resetSequence();
    sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rv = 1'($urandom_range(0, 1));
      pv = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      pd = $urandom;
      applyStimulus(rv, sel, pv, pd);
      if (rv) sel = ~sel;
      checkOutput($sformatf("rand%0d", i));
    end

    // Random traffic with orphan responses allowed.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
      checkOutput($sformatf("orph%0d", i));
    end

    // Asynchronous reset with two reads outstanding, then a late response.
    resetSequence();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h5A5A1234);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("prereset");
    driveInputs(1'b0, 1'b0, 1'b0, '0);
    #3 reset = 1'b1;
    #1;
    check("async.y0",        bus.y0, 32'h0);
    check("async.y1",        bus.y1, 32'h0);
    check("async.pending",   32'(bus.pending), 32'h0);
    check("async.req_ready", 32'(bus.req_ready), 32'h1);
    check("async.y0_valid",  32'(bus.y0_valid), 32'h0);
    check("async.err",       32'(bus.err), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h77778888);
    checkOutput("late");
    check("late.err", 32'(bus.err), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
